// File: rtl/wavegen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wavegen_pkg : shared mode encoding and default widths for wavegen    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wavegen_pkg;

   localparam int c_DEF_DATA_W = 10;
   localparam int c_DEF_ACC_W  = 16;

   typedef enum logic [1:0] {
      MODE_SAW  = 2'd0,
      MODE_TRI  = 2'd1,
      MODE_SQR  = 2'd2,
      MODE_RSAW = 2'd3
   } mode_e;

endpackage
`default_nettype wire

// File: rtl/wavegen_shaper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wavegen_shaper : combinational phase-to-sample mapping per mode      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wavegen_shaper
   import wavegen_pkg::*;
#(
   parameter int DATA_W = c_DEF_DATA_W
) (
   input  logic [DATA_W-1:0] p,
   input  mode_e             mode,
   input  logic [DATA_W-1:0] duty,
   output logic [DATA_W-1:0] sample
);

   logic [DATA_W-2:0] w_tri;

   always_comb begin
      // Second half-period folds the lower phase bits back down.
      w_tri  = p[DATA_W-1] ? ~p[DATA_W-2:0] : p[DATA_W-2:0];
      sample = '0;
      case (mode)
         MODE_SAW: sample = p;
         MODE_TRI: sample = {w_tri, 1'b0};
         MODE_SQR: sample = (p < duty) ? '1 : '0;
         default:  sample = ~p;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/wavegen_dds.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wavegen_dds : phase-accumulator waveform generator with shadowed     |
// |               configuration applied on period boundaries             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wavegen_dds
   import wavegen_pkg::*;
#(
   parameter int          DATA_W   = c_DEF_DATA_W,
   parameter int          ACC_W    = c_DEF_ACC_W,    // must be >= DATA_W+1
   parameter int unsigned FTW_RST  = 2**(ACC_W-DATA_W),
   parameter logic [1:0]  MODE_RST = 2'd0
) (
   input  logic              dac_clk,
   input  logic              dac_rst,
   input  logic              en,
   input  logic              cfg_load,
   input  logic [ACC_W-1:0]  cfg_ftw,
   input  logic [1:0]        cfg_mode,
   input  logic [DATA_W-1:0] cfg_duty,
   output logic              cfg_ack,
   output logic [DATA_W-1:0] dac_data,
   output logic              sync
);

   localparam logic [ACC_W-1:0]  c_FTW_RST  = ACC_W'(FTW_RST);
   localparam mode_e             c_MODE_RST = mode_e'(MODE_RST);
   localparam logic [DATA_W-1:0] c_DUTY_RST = {1'b1, {(DATA_W-1){1'b0}}};

   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  r_ftw_act;
   mode_e             r_mode_act;
   logic [DATA_W-1:0] r_duty_act;
   logic [ACC_W-1:0]  r_ftw_shd;
   mode_e             r_mode_shd;
   logic [DATA_W-1:0] r_duty_shd;
   logic              r_pending;
   logic              r_wrap_d;
   logic              r_sync;
   logic              r_ack;
   logic [DATA_W-1:0] r_dac_data;

   logic [ACC_W:0]    w_sum;
   logic              w_wrap;
   logic              w_apply;
   logic [DATA_W-1:0] w_phase;
   logic [DATA_W-1:0] w_sample;

   assign w_sum   = {1'b0, r_acc} + {1'b0, r_ftw_act};
   assign w_wrap  = en & w_sum[ACC_W];
   // Running: switch only at a period boundary. Idle: switch immediately.
   assign w_apply = r_pending & (~en | w_wrap);
   assign w_phase = r_acc[ACC_W-1 -: DATA_W];

   wavegen_shaper #(
      .DATA_W (DATA_W)
   ) u_shaper (
      .p      (w_phase),
      .mode   (r_mode_act),
      .duty   (r_duty_act),
      .sample (w_sample)
   );

   always_ff @(posedge dac_clk or posedge dac_rst) begin
      if (dac_rst) begin
         r_acc      <= '0;
         r_ftw_act  <= c_FTW_RST;
         r_mode_act <= c_MODE_RST;
         r_duty_act <= c_DUTY_RST;
         r_ftw_shd  <= c_FTW_RST;
         r_mode_shd <= c_MODE_RST;
         r_duty_shd <= c_DUTY_RST;
         r_pending  <= 1'b0;
         r_wrap_d   <= 1'b0;
         r_sync     <= 1'b0;
         r_ack      <= 1'b0;
         r_dac_data <= '0;
      end else begin
         if (en) begin
            r_acc <= w_sum[ACC_W-1:0];
         end
         // Two stages so sync lines up with the first post-wrap sample.
         r_wrap_d   <= w_wrap;
         r_sync     <= r_wrap_d;
         r_ack      <= w_apply;
         r_dac_data <= w_sample;

         if (w_apply) begin
            r_ftw_act  <= r_ftw_shd;
            r_mode_act <= r_mode_shd;
            r_duty_act <= r_duty_shd;
         end

         // A load coinciding with an apply keeps the new values pending.
         if (cfg_load) begin
            r_ftw_shd  <= cfg_ftw;
            r_mode_shd <= mode_e'(cfg_mode);
            r_duty_shd <= cfg_duty;
            r_pending  <= 1'b1;
         end else if (w_apply) begin
            r_pending  <= 1'b0;
         end
      end
   end

   assign dac_data = r_dac_data;
   assign sync     = r_sync;
   assign cfg_ack  = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_wavegen_dds.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wavegen_dds : directed self-checking bench for wavegen_dds        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wavegen_dds;

   logic        dac_clk;
   logic        dac_rst;
   logic        en;
   logic        cfg_load;
   logic [15:0] cfg_ftw;
   logic [1:0]  cfg_mode;
   logic [9:0]  cfg_duty;
   logic        cfg_ack;
   logic [9:0]  dac_data;
   logic        sync;

   int checks = 0;
   int errors = 0;

   wavegen_dds #(
      .DATA_W (10),
      .ACC_W  (16)
   ) dut (
      .dac_clk  (dac_clk),
      .dac_rst  (dac_rst),
      .en       (en),
      .cfg_load (cfg_load),
      .cfg_ftw  (cfg_ftw),
      .cfg_mode (cfg_mode),
      .cfg_duty (cfg_duty),
      .cfg_ack  (cfg_ack),
      .dac_data (dac_data),
      .sync     (sync)
   );

   initial dac_clk = 1'b0;
   always #5 dac_clk = ~dac_clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge dac_clk);
      #1;
   endtask

   function automatic logic [9:0] tri_of(input int p);
      return (p < 512) ? 10'(2 * p) : 10'(2 * (1023 - p));
   endfunction

   task automatic apply_reset();
      en       = 1'b0;
      cfg_load = 1'b0;
      cfg_ftw  = '0;
      cfg_mode = '0;
      cfg_duty = '0;
      dac_rst  = 1'b1;
      tick();
      tick();
      dac_rst  = 1'b0;
   endtask

   task automatic config_idle(input logic [15:0] ftw, input logic [1:0] mode,
                              input logic [9:0] duty);
      en       = 1'b0;
      cfg_ftw  = ftw;
      cfg_mode = mode;
      cfg_duty = duty;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      en = 1'b0; cfg_load = 1'b0; cfg_ftw = '0; cfg_mode = '0; cfg_duty = '0;
      dac_rst = 1'b1;
      #2;
      checks++;
      if (dac_data !== 10'd0) begin
         errors++; $display("FAIL reset_dac_data got %0d expected 0", dac_data);
      end
      checks++;
      if (sync !== 1'b0) begin
         errors++; $display("FAIL reset_sync got %b expected 0", sync);
      end
      checks++;
      if (cfg_ack !== 1'b0) begin
         errors++; $display("FAIL reset_cfg_ack got %b expected 0", cfg_ack);
      end
      tick();
      dac_rst = 1'b0;
   endtask

   task automatic test_saw();
      logic [9:0] exp_d;
      logic       exp_s;
      apply_reset();
      en = 1'b1;
      for (int k = 1; k <= 2100; k++) begin
         tick();
         exp_d = 10'((k - 1) % 1024);
         exp_s = (k > 1) && ((k - 1) % 1024 == 0);
         checks++;
         if (dac_data !== exp_d) begin
            errors++; $display("FAIL saw_data k=%0d got %0d expected %0d", k, dac_data, exp_d);
         end
         checks++;
         if (sync !== exp_s) begin
            errors++; $display("FAIL saw_sync k=%0d got %b expected %b", k, sync, exp_s);
         end
      end
   endtask

   task automatic test_tri();
      logic [9:0] exp_d;
      logic       exp_s;
      apply_reset();
      cfg_ftw = 16'd64; cfg_mode = 2'd1; cfg_duty = 10'd0;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      checks++;
      if (cfg_ack !== 1'b0) begin
         errors++; $display("FAIL tri_ack_early got %b expected 0", cfg_ack);
      end
      tick();
      checks++;
      if (cfg_ack !== 1'b1) begin
         errors++; $display("FAIL tri_ack_idle got %b expected 1", cfg_ack);
      end
      en = 1'b1;
      for (int k = 1; k <= 1100; k++) begin
         tick();
         exp_d = tri_of((k - 1) % 1024);
         exp_s = (k > 1) && ((k - 1) % 1024 == 0);
         checks++;
         if (dac_data !== exp_d) begin
            errors++; $display("FAIL tri_data k=%0d got %0d expected %0d", k, dac_data, exp_d);
         end
         checks++;
         if (sync !== exp_s) begin
            errors++; $display("FAIL tri_sync k=%0d got %b expected %b", k, sync, exp_s);
         end
         if (k == 1) begin
            checks++;
            if (cfg_ack !== 1'b0) begin
               errors++; $display("FAIL tri_ack_width got %b expected 0", cfg_ack);
            end
         end
      end
   endtask

   task automatic test_sqr();
      logic [9:0] exp_d;
      apply_reset();
      config_idle(16'd64, 2'd2, 10'd256);
      en = 1'b1;
      for (int k = 1; k <= 2100; k++) begin
         tick();
         exp_d = (((k - 1) % 1024) < 256) ? 10'd1023 : 10'd0;
         checks++;
         if (dac_data !== exp_d) begin
            errors++; $display("FAIL sqr_data k=%0d got %0d expected %0d", k, dac_data, exp_d);
         end
      end
      config_idle(16'd64, 2'd2, 10'd0);
      en = 1'b1;
      for (int k = 1; k <= 1100; k++) begin
         tick();
         checks++;
         if (dac_data !== 10'd0) begin
            errors++; $display("FAIL sqr_duty0 k=%0d got %0d expected 0", k, dac_data);
         end
      end
   endtask

   task automatic test_rsaw();
      logic [9:0] exp_d;
      apply_reset();
      config_idle(16'd64, 2'd3, 10'd512);
      en = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         tick();
         exp_d = 10'(1023 - ((k - 1) % 1024));
         checks++;
         if (dac_data !== exp_d) begin
            errors++; $display("FAIL rsaw_data k=%0d got %0d expected %0d", k, dac_data, exp_d);
         end
      end
   endtask

   task automatic test_en_hold();
      apply_reset();
      en = 1'b1;
      for (int k = 1; k <= 100; k++) tick();
      en = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (dac_data !== 10'd100) begin
            errors++; $display("FAIL hold_data k=%0d got %0d expected 100", k, dac_data);
         end
      end
      en = 1'b1;
      tick();
      checks++;
      if (dac_data !== 10'd100) begin
         errors++; $display("FAIL hold_resume0 got %0d expected 100", dac_data);
      end
      tick();
      checks++;
      if (dac_data !== 10'd101) begin
         errors++; $display("FAIL hold_resume1 got %0d expected 101", dac_data);
      end
   endtask

   task automatic test_freeze();
      apply_reset();
      config_idle(16'd0, 2'd0, 10'd512);
      en = 1'b1;
      cfg_ftw = 16'd64; cfg_mode = 2'd1; cfg_duty = 10'd512;
      for (int k = 1; k <= 20; k++) begin
         cfg_load = (k == 5);
         tick();
         checks++;
         if (dac_data !== 10'd0 || sync !== 1'b0 || cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL freeze k=%0d got data=%0d sync=%b ack=%b expected 0/0/0",
                     k, dac_data, sync, cfg_ack);
         end
      end
      cfg_load = 1'b0;
      en = 1'b0;
      tick();
      checks++;
      if (cfg_ack !== 1'b1) begin
         errors++; $display("FAIL freeze_apply_idle got %b expected 1", cfg_ack);
      end
      tick();
      checks++;
      if (cfg_ack !== 1'b0) begin
         errors++; $display("FAIL freeze_ack_width got %b expected 0", cfg_ack);
      end
   endtask

   task automatic test_cfg_midperiod();
      logic [9:0] exp_d;
      logic       exp_s;
      logic       exp_a;
      apply_reset();
      en = 1'b1;
      cfg_ftw = 16'd128; cfg_mode = 2'd0; cfg_duty = 10'd512;
      for (int k = 1; k <= 1600; k++) begin
         cfg_load = (k == 301);
         tick();
         exp_d = (k <= 1024) ? 10'((k - 1) % 1024) : 10'(((k - 1025) * 2) % 1024);
         exp_s = (k == 1025) || (k == 1537);
         exp_a = (k == 1024);
         checks++;
         if (dac_data !== exp_d) begin
            errors++; $display("FAIL mid_data k=%0d got %0d expected %0d", k, dac_data, exp_d);
         end
         checks++;
         if (sync !== exp_s) begin
            errors++; $display("FAIL mid_sync k=%0d got %b expected %b", k, sync, exp_s);
         end
         checks++;
         if (cfg_ack !== exp_a) begin
            errors++; $display("FAIL mid_ack k=%0d got %b expected %b", k, cfg_ack, exp_a);
         end
      end
      cfg_load = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp_d;
      logic       exp_s;
      logic       exp_a;
      apply_reset();
      en = 1'b1;
      for (int k = 1; k <= 1850; k++) begin
         cfg_load = 1'b0;
         if (k == 500) begin
            cfg_load = 1'b1; cfg_ftw = 16'd128; cfg_mode = 2'd0; cfg_duty = 10'd512;
         end else if (k == 1024) begin
            cfg_load = 1'b1; cfg_ftw = 16'd256; cfg_mode = 2'd1; cfg_duty = 10'd512;
         end
         tick();
         if (k <= 1024)
            exp_d = 10'((k - 1) % 1024);
         else if (k <= 1536)
            exp_d = 10'(((k - 1025) * 2) % 1024);
         else
            exp_d = tri_of(((k - 1537) * 4) % 1024);
         exp_s = (k == 1025) || (k == 1537) || (k == 1793);
         exp_a = (k == 1024) || (k == 1536);
         checks++;
         if (dac_data !== exp_d) begin
            errors++; $display("FAIL b2b_data k=%0d got %0d expected %0d", k, dac_data, exp_d);
         end
         checks++;
         if (sync !== exp_s) begin
            errors++; $display("FAIL b2b_sync k=%0d got %b expected %b", k, sync, exp_s);
         end
         checks++;
         if (cfg_ack !== exp_a) begin
            errors++; $display("FAIL b2b_ack k=%0d got %b expected %b", k, cfg_ack, exp_a);
         end
      end
      cfg_load = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [9:0] exp_d;
      logic       exp_s;
      apply_reset();
      en = 1'b1;
      cfg_ftw = 16'd512; cfg_mode = 2'd2; cfg_duty = 10'd100;
      for (int k = 1; k <= 600; k++) begin
         cfg_load = (k == 400);
         tick();
      end
      cfg_load = 1'b0;
      checks++;
      if (dac_data !== 10'd599) begin
         errors++; $display("FAIL rstmid_pre got %0d expected 599", dac_data);
      end
      #2;
      dac_rst = 1'b1;
      #1;
      checks++;
      if (dac_data !== 10'd0 || sync !== 1'b0 || cfg_ack !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async got data=%0d sync=%b ack=%b expected 0/0/0",
                  dac_data, sync, cfg_ack);
      end
      tick();
      dac_rst = 1'b0;
      for (int k = 1; k <= 1100; k++) begin
         tick();
         exp_d = 10'((k - 1) % 1024);
         exp_s = (k > 1) && ((k - 1) % 1024 == 0);
         checks++;
         if (dac_data !== exp_d) begin
            errors++; $display("FAIL rstmid_data k=%0d got %0d expected %0d", k, dac_data, exp_d);
         end
         checks++;
         if (sync !== exp_s || cfg_ack !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flags k=%0d got sync=%b ack=%b expected %b/0",
                     k, sync, cfg_ack, exp_s);
         end
      end
   endtask

   initial begin
      test_reset();
      test_saw();
      test_tri();
      test_sqr();
      test_rsaw();
      test_en_hold();
      test_freeze();
      test_cfg_midperiod();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wavegen_dds.md
WAVEGEN_DDS -- requirements
Module: wavegen_dds

Interface
REQ-001 Parameter DATA_W, 10: DAC sample width in bits.
REQ-002 Parameter ACC_W, 16: phase-accumulator width; SHALL satisfy ACC_W >= DATA_W+1.
REQ-003 Parameter FTW_RST, 2**(ACC_W-DATA_W): tuning word after reset (one DAC LSB per clock).
REQ-004 Parameter MODE_RST, 0 (SAW): waveform mode after reset.
REQ-005 Port dac_clk, input, 1: sole clock; all state rising-edge.
REQ-006 Port dac_rst, input, 1: asynchronous, active-high reset.
REQ-007 Port en, input, 1: accumulator advance enable.
REQ-008 Port cfg_load, input, 1: single-cycle strobe capturing cfg_ftw/cfg_mode/cfg_duty into shadow registers.
REQ-009 Port cfg_ftw, input, ACC_W: requested frequency tuning word.
REQ-010 Port cfg_mode, input, 2: 0 SAW, 1 TRI, 2 SQR, 3 RSAW.
REQ-011 Port cfg_duty, input, DATA_W: square-wave threshold.
REQ-012 Port cfg_ack, output, 1: one-cycle pulse when shadow config becomes active.
REQ-013 Port dac_data, output, DATA_W: registered sample.
REQ-014 Port sync, output, 1: one-cycle pulse marking first sample of each period.

Function
REQ-015 Accumulator acc SHALL update acc <= acc + ftw_act (mod 2**ACC_W) on each cycle with en=1, and hold when en=0.
REQ-016 wrap SHALL be the carry-out of that addition when en=1; wrap is 0 when en=0 or ftw_act=0.
REQ-017 Phase p SHALL be acc[ACC_W-1 -: DATA_W] (current register value).
REQ-018 SAW: dac_data <= p.
REQ-019 TRI: t = p[DATA_W-2:0]; dac_data <= {(p[MSB] ? ~t : t), 1'b0}; range 0..2**DATA_W-2.
REQ-020 SQR: dac_data <= (p < duty_act) ? all-ones : 0; duty_act=0 gives constant 0.
REQ-021 RSAW: dac_data <= ~p.
REQ-022 dac_data SHALL lag acc by exactly one clock and be updated every cycle, including when en=0.
REQ-023 sync SHALL be registered from wrap so it is high in the same cycle as the first post-wrap dac_data sample.
REQ-024 cfg_load SHALL set pending=1 and overwrite shadow registers; repeated loads before apply keep only the latest values.
REQ-025 While en=1, a pending config SHALL be applied (active <= shadow, pending <= 0, cfg_ack pulse next cycle) only on a wrap cycle, giving glitch-free period boundaries.
REQ-026 While en=0, a pending config SHALL be applied on the next clock edge.
REQ-027 When cfg_load coincides with an apply cycle, the previous shadow SHALL be applied and the new values captured to shadow, pending remaining 1.
REQ-028 Applying a config SHALL NOT reset acc; phase is continuous across frequency changes.
REQ-029 ftw_act=0 with en=1 SHALL freeze phase and suppress wrap; pending config then applies only after en=0.

Reset
REQ-030 dac_rst SHALL asynchronously force acc=0, dac_data=0, sync=0, cfg_ack=0, pending=0, ftw_act=FTW_RST, mode_act=MODE_RST, duty_act=2**(DATA_W-1), shadow = active.
REQ-031 Reset asserted mid-period SHALL discard any pending config; the first sample after release SHALL be the reset-mode value for p=0.

Structure
REQ-032 Package wavegen_pkg SHALL hold the mode encoding (SAW/TRI/SQR/RSAW) and default DATA_W/ACC_W constants.
REQ-033 Mode-to-sample mapping SHALL be one combinational sub-module, wavegen_shaper (inputs p, mode, duty; output sample); all registers in wavegen_dds.

Verification (DATA_W=10, ACC_W=16)
REQ-034 Reset release, en=1, defaults -> dac_data 0,1,2,...,1023,0; sync high with each 0 sample, period 1024 clocks.
REQ-035 TRI, ftw=64 -> ramp 0,2,...,1022, 1022,1020,...,0; period 1024 clocks, no sample outside 0..1022.
REQ-036 SQR, duty=256, ftw=64 -> 1023 for 256 clocks then 0 for 768 clocks, repeating.
REQ-037 cfg_load ftw=128 mid-period with en=1 -> old slope continues to wrap; cfg_ack one cycle after wrap; next period 512 clocks.
REQ-038 cfg_load on the exact wrap cycle with a different pending config -> older config applied with ack; new one applied and acked at the following wrap.
REQ-039 dac_rst asserted mid-ramp with pending config -> outputs 0 immediately (async), pending lost, defaults resume from 0.
